// File: rtl/m_pcpi_adapter.sv
// -----------------------------------------------------------------------------
// m_pcpi_adapter
//
// Front-end between the PicoRV32 PCPI port and an RV32M execution unit.
// Decodes RV32M instructions, registers the instruction and operands towards
// the unit and holds the request until the unit answers. The unit's
// single-cycle answer is turned into a one-cycle PCPI ready/wr response.
// A watchdog forces a null response if the unit stalls. An optional one-entry
// cache answers an exact repeat (same funct3 and operands) without issuing.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in WAIT before a forced response (1..255)
//   ENABLE_CACHE    1 = one-entry repeat-result cache enabled
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2  core request (held until pcpi_ready)
//   pcpi_wr/rd/wait/ready    response towards the core
//   m_valid                  request to the M unit, held until m_ready
//   m_instruction/rs1/rs2    registered instruction and operands
//   m_wr/m_rd/m_ready        M unit answer (m_ready is a one-cycle pulse)
//   m_busy                   M unit busy status, used only to leave ABORT
//   timeout_err              sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module m_pcpi_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          ENABLE_CACHE   = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,

  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_ready,
  input  logic        m_busy,

  output logic        timeout_err
);

  // state  | meaning
  // IDLE   | waiting for a matching RV32M request
  // WAIT   | request issued to the unit, core stalled, watchdog running
  // RESP   | one-cycle pcpi_ready with the captured result
  // DRAIN  | one cycle while the core drops pcpi_valid
  // ABORT  | after a timeout: wait for the unit to finish or go idle
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RESP  = 3'd2,
    S_DRAIN = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;

  logic [31:0] res_rd_q, res_rd_d;
  logic        res_wr_q, res_wr_d;
  // fill: the pending response is a fresh unit result and goes into the cache
  logic        fill_q, fill_d;
  // tmo: the pending response was forced by the watchdog, RESP exits to ABORT
  logic        tmo_q, tmo_d;
  logic        err_q, err_d;

  logic        c_valid_q, c_valid_d;
  logic [2:0]  c_f3_q, c_f3_d;
  logic [31:0] c_rs1_q, c_rs1_d;
  logic [31:0] c_rs2_q, c_rs2_d;
  logic [31:0] c_rd_q, c_rd_d;
  logic        c_wr_q, c_wr_d;

  logic        is_m;
  logic        cache_hit;

  assign is_m = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);

  // funct3 alone identifies the M operation once the opcode/funct7 match.
  assign cache_hit = ENABLE_CACHE && c_valid_q &&
                     (c_f3_q  == pcpi_insn[14:12]) &&
                     (c_rs1_q == pcpi_rs1) &&
                     (c_rs2_q == pcpi_rs2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      insn_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      res_rd_q  <= '0;
      res_wr_q  <= 1'b0;
      fill_q    <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
      c_valid_q <= 1'b0;
      c_f3_q    <= '0;
      c_rs1_q   <= '0;
      c_rs2_q   <= '0;
      c_rd_q    <= '0;
      c_wr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      insn_q    <= insn_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      res_rd_q  <= res_rd_d;
      res_wr_q  <= res_wr_d;
      fill_q    <= fill_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      c_valid_q <= c_valid_d;
      c_f3_q    <= c_f3_d;
      c_rs1_q   <= c_rs1_d;
      c_rs2_q   <= c_rs2_d;
      c_rd_q    <= c_rd_d;
      c_wr_q    <= c_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    insn_d    = insn_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    res_rd_d  = res_rd_q;
    res_wr_d  = res_wr_q;
    fill_d    = fill_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    c_valid_d = c_valid_q;
    c_f3_d    = c_f3_q;
    c_rs1_d   = c_rs1_q;
    c_rs2_d   = c_rs2_q;
    c_rd_d    = c_rd_q;
    c_wr_d    = c_wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (pcpi_valid && is_m) begin
          if (cache_hit) begin
            res_rd_d = c_rd_q;
            res_wr_d = c_wr_q;
            fill_d   = 1'b0;
            tmo_d    = 1'b0;
            state_d  = S_RESP;
          end else begin
            insn_d  = pcpi_insn;
            rs1_d   = pcpi_rs1;
            rs2_d   = pcpi_rs2;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // m_ready wins over the watchdog when both happen in the same cycle.
        if (m_ready) begin
          if (pcpi_valid) begin
            res_rd_d = m_rd;
            res_wr_d = m_wr;
            fill_d   = 1'b1;
            tmo_d    = 1'b0;
            state_d  = S_RESP;
          end else begin
            // Core withdrew the request: drop the result, leave the cache alone.
            state_d = S_DRAIN;
          end
        end else if (cnt_q == TMO_LIMIT) begin
          res_rd_d = '0;
          res_wr_d = 1'b0;
          fill_d   = 1'b0;
          tmo_d    = 1'b1;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (fill_q && ENABLE_CACHE) begin
          c_valid_d = 1'b1;
          c_f3_d    = insn_q[14:12];
          c_rs1_d   = rs1_q;
          c_rs2_d   = rs2_q;
          c_rd_d    = res_rd_q;
          c_wr_d    = res_wr_q;
        end
        fill_d  = 1'b0;
        state_d = tmo_q ? S_ABORT : S_DRAIN;
      end

      S_DRAIN: begin
        state_d = S_IDLE;
      end

      S_ABORT: begin
        tmo_d = 1'b0;
        if (m_ready || !m_busy) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs are decodes of registered state, so they drop to zero as soon
  // as resetn is asserted.
  assign m_valid       = (state_q == S_WAIT);
  assign pcpi_wait     = (state_q == S_WAIT) || (state_q == S_RESP);
  assign pcpi_ready    = (state_q == S_RESP);
  assign pcpi_wr       = (state_q == S_RESP) && res_wr_q;
  assign pcpi_rd       = (state_q == S_RESP) ? res_rd_q : 32'd0;
  assign m_instruction = insn_q;
  assign m_rs1         = rs1_q;
  assign m_rs2         = rs2_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_m_pcpi_adapter.sv
module tb_m_pcpi_adapter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        sel_n;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        m_ready, m_wr, m_busy;
  logic [31:0] m_rd;

  logic        c_wr, c_wait, c_ready, c_mv, c_err;
  logic [31:0] c_rd, c_mi, c_m1, c_m2;
  logic        n_wr, n_wait, n_ready, n_mv, n_err;
  logic [31:0] n_rd, n_mi, n_m1, n_m2;
  logic        o_wr, o_wait, o_ready, o_mv, o_err;
  logic [31:0] o_rd, o_mi, o_m1, o_m2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  m_pcpi_adapter #(.TIMEOUT_CYCLES(T), .ENABLE_CACHE(1'b1)) dut_c (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid & ~sel_n), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(c_wr), .pcpi_rd(c_rd), .pcpi_wait(c_wait), .pcpi_ready(c_ready),
    .m_valid(c_mv), .m_instruction(c_mi), .m_rs1(c_m1), .m_rs2(c_m2),
    .m_wr(m_wr), .m_rd(m_rd), .m_ready(m_ready & ~sel_n), .m_busy(m_busy),
    .timeout_err(c_err)
  );

  m_pcpi_adapter #(.TIMEOUT_CYCLES(T), .ENABLE_CACHE(1'b0)) dut_n (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid & sel_n), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(n_wr), .pcpi_rd(n_rd), .pcpi_wait(n_wait), .pcpi_ready(n_ready),
    .m_valid(n_mv), .m_instruction(n_mi), .m_rs1(n_m1), .m_rs2(n_m2),
    .m_wr(m_wr), .m_rd(m_rd), .m_ready(m_ready & sel_n), .m_busy(m_busy),
    .timeout_err(n_err)
  );

  assign o_wr    = sel_n ? n_wr    : c_wr;
  assign o_rd    = sel_n ? n_rd    : c_rd;
  assign o_wait  = sel_n ? n_wait  : c_wait;
  assign o_ready = sel_n ? n_ready : c_ready;
  assign o_mv    = sel_n ? n_mv    : c_mv;
  assign o_mi    = sel_n ? n_mi    : c_mi;
  assign o_m1    = sel_n ? n_m1    : c_m1;
  assign o_m2    = sel_n ? n_m2    : c_m2;
  assign o_err   = sel_n ? n_err   : c_err;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    logic [31:0] urd;
    logic        uwr;
    int          exp_rdy;
    logic [31:0] exp_rd;
    logic        exp_wr;
    int          exp_mv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_m(input logic [2:0] f3);
    return {7'b0000001, 5'd11, 5'd10, f3, 5'd10, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_nonm(input logic [2:0] f3);
    return {7'b0000000, 5'd11, 5'd10, f3, 5'd10, 7'b0110011};
  endfunction

  // Architectural RV32M result, used as the unit's answer.
  function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    pcpi_valid = 1'b0;
    m_ready = 1'b0;
    m_busy = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Plays one core request plus the unit's behaviour for ncyc cycles starting
  // at the current negedge (= cycle 0). k is the cycle of the m_ready pulse
  // (0 = never); drop_c is the cycle from which the core withdraws (0 = never).
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input int k, input logic [31:0] urd, input logic uwr,
                         input int drop_c, input logic busy, input int ncyc,
                         output int rdy_c, output int rdy_n,
                         output logic [31:0] got_rd, output logic got_wr,
                         output int mv_n, output int wt_n, output int stab_bad);
    rdy_c = -1; rdy_n = 0; got_rd = '0; got_wr = 1'b0;
    mv_n = 0; wt_n = 0; stab_bad = 0;
    pcpi_insn = insn;
    pcpi_rs1 = a;
    pcpi_rs2 = b;
    for (int c = 0; c < ncyc; c++) begin
      if (o_ready) begin
        rdy_n++;
        if (rdy_c < 0) begin
          rdy_c = c;
          got_rd = o_rd;
          got_wr = o_wr;
        end
      end
      if (o_mv) begin
        mv_n++;
        if (o_mi !== insn || o_m1 !== a || o_m2 !== b) stab_bad++;
      end
      if (o_wait) wt_n++;
      pcpi_valid = (rdy_c < 0 || rdy_c == c) && (drop_c == 0 || c < drop_c);
      m_ready = (k > 0 && c == k);
      m_rd = m_ready ? urd : (32'hBAD0_0000 ^ 32'(c));
      m_wr = m_ready ? uwr : ~uwr;
      m_busy = busy;
      @(negedge clk);
    end
    pcpi_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        tbl[11];
    int          rc, rn, mv, wt, sb;
    logic [31:0] grd;
    logic        gwr;
    logic        mc_v, mc_wr, merr;
    logic [2:0]  mc_f3;
    logic [31:0] mc_a, mc_b, mc_rd;
    logic [31:0] pool[4];

    sel_n = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn = '0;
    pcpi_rs1 = '0;
    pcpi_rs2 = '0;
    m_ready = 1'b0;
    m_wr = 1'b0;
    m_rd = '0;
    m_busy = 1'b0;

    #1 resetn = 1'b0;
    #1;
    chk("reset pcpi_ready", {31'd0, o_ready}, 32'd0);
    chk("reset pcpi_wait", {31'd0, o_wait}, 32'd0);
    chk("reset m_valid", {31'd0, o_mv}, 32'd0);
    chk("reset pcpi_rd", o_rd, 32'd0);
    chk("reset m_rs1", o_m1, 32'd0);
    chk("reset timeout_err", {31'd0, o_err}, 32'd0);

    tbl[0]  = '{mk_m(3'd0), 32'd7,   32'd6, 5, 32'd42,  1'b1, 6,  32'd42,  1'b1, 5};
    tbl[1]  = '{mk_m(3'd4), 32'd100, 32'd7, 3, 32'd14,  1'b1, 4,  32'd14,  1'b1, 3};
    tbl[2]  = '{mk_m(3'd4), 32'd100, 32'd7, 3, 32'h55,  1'b1, 1,  32'd14,  1'b1, 0};
    tbl[3]  = '{mk_m(3'd5), 32'd100, 32'd7, 2, 32'd14,  1'b1, 3,  32'd14,  1'b1, 2};
    tbl[4]  = '{mk_m(3'd0), 32'd7,   32'd6, 1, 32'd42,  1'b1, 2,  32'd42,  1'b1, 1};
    tbl[5]  = '{mk_m(3'd1), 32'd7,   32'd6, 4, 32'd0,   1'b1, 5,  32'd0,   1'b1, 4};
    tbl[6]  = '{32'h00B5_0533, 32'd3, 32'd4, 3, 32'd7,  1'b1, -1, 32'd0,   1'b0, 0};
    tbl[7]  = '{32'h02B5_0513, 32'd3, 32'd4, 2, 32'd7,  1'b1, -1, 32'd0,   1'b0, 0};
    tbl[8]  = '{mk_m(3'd6), 32'd7,   32'd6, 9, 32'd1,   1'b0, 10, 32'd1,   1'b0, 9};
    tbl[9]  = '{mk_m(3'd6), 32'd7,   32'd6, 4, 32'hBAD, 1'b1, 1,  32'd1,   1'b0, 0};
    tbl[10] = '{mk_m(3'd6), 32'd7, 32'h8000_0006, 2, 32'h77, 1'b1, 3, 32'h77, 1'b1, 2};

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].insn, tbl[i].a, tbl[i].b, tbl[i].k, tbl[i].urd, tbl[i].uwr,
              0, 1'b0, 20, rc, rn, grd, gwr, mv, wt, sb);
      chk($sformatf("vec%0d ready_cycle", i), rc, tbl[i].exp_rdy);
      chk($sformatf("vec%0d ready_count", i), rn, (tbl[i].exp_rdy < 0) ? 0 : 1);
      if (tbl[i].exp_rdy >= 0) begin
        chk($sformatf("vec%0d pcpi_rd", i), grd, tbl[i].exp_rd);
        chk($sformatf("vec%0d pcpi_wr", i), {31'd0, gwr}, {31'd0, tbl[i].exp_wr});
      end
      chk($sformatf("vec%0d m_valid_cycles", i), mv, tbl[i].exp_mv);
      chk($sformatf("vec%0d wait_cycles", i), wt, (tbl[i].exp_rdy < 0) ? 0 : tbl[i].exp_rdy);
      chk($sformatf("vec%0d operand_stability", i), sb, 0);
    end

    // Unit never answers: forced empty response, then ABORT until m_busy drops.
    run_txn(mk_m(3'd2), 32'd5, 32'd5, 0, 32'd0, 1'b0, 0, 1'b1, 20, rc, rn, grd, gwr, mv, wt, sb);
    chk("timeout ready_cycle", rc, T + 2);
    chk("timeout pcpi_rd", grd, 32'd0);
    chk("timeout pcpi_wr", {31'd0, gwr}, 32'd0);
    chk("timeout m_valid_cycles", mv, T + 1);
    chk("timeout wait_cycles", wt, T + 2);
    chk("timeout_err set", {31'd0, o_err}, 32'd1);
    run_txn(mk_m(3'd0), 32'd2, 32'd3, 0, 32'd6, 1'b1, 0, 1'b1, 10, rc, rn, grd, gwr, mv, wt, sb);
    chk("abort ignores request ready", rc, -1);
    chk("abort ignores request m_valid", mv, 0);
    chk("abort ignores request wait", wt, 0);
    m_busy = 1'b0;
    repeat (2) @(negedge clk);
    run_txn(mk_m(3'd2), 32'd5, 32'd5, 3, 32'h1234, 1'b1, 0, 1'b0, 10, rc, rn, grd, gwr, mv, wt, sb);
    chk("post-abort ready_cycle", rc, 4);
    chk("post-abort pcpi_rd", grd, 32'h1234);
    chk("post-abort miss m_valid_cycles", mv, 3);
    chk("timeout_err sticky", {31'd0, o_err}, 32'd1);

    // Asynchronous reset in the middle of WAIT.
    pcpi_insn = mk_m(3'd0);
    pcpi_rs1 = 32'd9;
    pcpi_rs2 = 32'd9;
    pcpi_valid = 1'b1;
    m_ready = 1'b0;
    m_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre-reset m_valid", {31'd0, o_mv}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async reset m_valid", {31'd0, o_mv}, 32'd0);
    chk("async reset pcpi_wait", {31'd0, o_wait}, 32'd0);
    chk("async reset m_instruction", o_mi, 32'd0);
    chk("async reset m_rs1", o_m1, 32'd0);
    chk("async reset timeout_err", {31'd0, o_err}, 32'd0);
    pcpi_valid = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_txn(mk_m(3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, rv32m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            1'b1, 0, 1'b0, 10, rc, rn, grd, gwr, mv, wt, sb);
    chk("mulhu ready_cycle", rc, 4);
    chk("mulhu pcpi_rd", grd, 32'hFFFF_FFFE);
    chk("mulhu pcpi_wr", {31'd0, gwr}, 32'd1);

    // Core withdraws before the unit answers; result dropped, cache untouched.
    run_txn(mk_m(3'd0), 32'd3, 32'd4, 5, 32'd12, 1'b1, 3, 1'b0, 8, rc, rn, grd, gwr, mv, wt, sb);
    chk("drop no ready", rc, -1);
    chk("drop m_valid_cycles", mv, 5);
    chk("drop wait_cycles", wt, 5);
    run_txn(mk_m(3'd0), 32'd3, 32'd4, 2, 32'd12, 1'b1, 0, 1'b0, 8, rc, rn, grd, gwr, mv, wt, sb);
    chk("after drop ready_cycle", rc, 3);
    chk("after drop pcpi_rd", grd, 32'd12);
    chk("after drop miss m_valid_cycles", mv, 2);

    // Cache disabled: identical requests both issue.
    sel_n = 1'b1;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      run_txn(mk_m(3'd4), 32'd100, 32'd7, 3, 32'd14, 1'b1, 0, 1'b0, 10, rc, rn, grd, gwr, mv, wt, sb);
      chk($sformatf("nocache%0d ready_cycle", r), rc, 4);
      chk($sformatf("nocache%0d pcpi_rd", r), grd, 32'd14);
      chk($sformatf("nocache%0d m_valid_cycles", r), mv, 3);
    end
    sel_n = 1'b0;

    // Randomized requests against an outcome-level model.
    do_reset();
    pool[0] = 32'd0;
    pool[1] = 32'd7;
    pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000;
    mc_v = 1'b0; mc_wr = 1'b0; merr = 1'b0;
    mc_f3 = '0; mc_a = '0; mc_b = '0; mc_rd = '0;
    for (int n = 0; n < 60; n++) begin
      logic        nonm, uwr, e_wr;
      logic [2:0]  f3;
      logic [31:0] a, b, urd, insn, e_rd;
      int          k, e_rdy, e_mv, e_wt;
      nonm = ($urandom_range(9) == 0);
      if (mc_v && $urandom_range(2) == 0) begin
        f3 = mc_f3; a = mc_a; b = mc_b;
      end else begin
        f3 = 3'($urandom_range(7));
        a = pool[$urandom_range(3)];
        b = pool[$urandom_range(3)];
      end
      insn = nonm ? mk_nonm(f3) : mk_m(f3);
      k = int'($urandom_range(11));
      urd = rv32m(f3, a, b);
      uwr = 1'($urandom_range(1));
      e_rd = '0; e_wr = 1'b0;
      if (nonm) begin
        e_rdy = -1; e_mv = 0; e_wt = 0;
      end else if (mc_v && mc_f3 == f3 && mc_a == a && mc_b == b) begin
        e_rdy = 1; e_rd = mc_rd; e_wr = mc_wr; e_mv = 0; e_wt = 1;
      end else if (k >= 1 && k <= T + 1) begin
        e_rdy = k + 1; e_rd = urd; e_wr = uwr; e_mv = k; e_wt = k + 1;
        mc_v = 1'b1; mc_f3 = f3; mc_a = a; mc_b = b; mc_rd = urd; mc_wr = uwr;
      end else begin
        e_rdy = T + 2; e_mv = T + 1; e_wt = T + 2; merr = 1'b1;
      end
      run_txn(insn, a, b, k, urd, uwr, 0, 1'b0, 14, rc, rn, grd, gwr, mv, wt, sb);
      chk($sformatf("rnd%0d ready_cycle", n), rc, e_rdy);
      chk($sformatf("rnd%0d ready_count", n), rn, (e_rdy < 0) ? 0 : 1);
      chk($sformatf("rnd%0d pcpi_rd", n), grd, e_rd);
      chk($sformatf("rnd%0d pcpi_wr", n), {31'd0, gwr}, {31'd0, e_wr});
      chk($sformatf("rnd%0d m_valid_cycles", n), mv, e_mv);
      chk($sformatf("rnd%0d wait_cycles", n), wt, e_wt);
      chk($sformatf("rnd%0d operand_stability", n), sb, 0);
      chk($sformatf("rnd%0d timeout_err", n), {31'd0, o_err}, {31'd0, merr});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
